// File: rtl/l1_l2_arbiter.sv
// Purpose: serialise I-cache and D-cache line misses onto the single L2 port, round-robin on conflict.
// Latency: L2 request 1 cycle after the L1 request is sampled; L1 resp 1 cycle after l2_resp.
// Backpressure: requests are level-held until resp; the loser of a conflict stays pending and is served next.
module l1_l2_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int LINE_WIDTH  = 128,
  parameter int OFFSET_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp,
  output logic [15:0]           i_grant_cnt,
  output logic [15:0]           d_grant_cnt
);

  typedef enum logic [1:0] {IDLE, L2_BUSY, RESPOND, RECOVER} state_t;

  // Clears the line offset so the L2 always sees a line-aligned address.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));

  state_t                  state;
  logic                    last_grant;  // 0 = I-cache, 1 = D-cache
  logic                    gnt_d;       // side owning the current transaction
  logic                    op_write;    // current transaction is a writeback
  logic [LINE_WIDTH-1:0]   line_buf;

  logic                    i_req;
  logic                    d_req;
  logic                    pick_d;
  logic                    pick_wr;
  logic [ADDR_WIDTH-1:0]   pick_addr;
  logic [LINE_WIDTH-1:0]   resp_line;

  // Grant selection: a lone requester wins; on conflict the side not granted last time wins.
  always_comb begin
    i_req     = i_read;
    d_req     = d_read | d_write;
    pick_d    = d_req & (~i_req | ~last_grant);
    pick_wr   = pick_d & d_write;
    pick_addr = (pick_d ? d_address : i_address) & ADDR_MASK;
    // Writes return the untouched buffer; reads return the fresh L2 line.
    resp_line = op_write ? line_buf : l2_rdata;
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      gnt_d       <= 1'b0;
      op_write    <= 1'b0;
      line_buf    <= '0;
      i_rdata     <= '0;
      i_resp      <= 1'b0;
      d_rdata     <= '0;
      d_resp      <= 1'b0;
      l2_read     <= 1'b0;
      l2_write    <= 1'b0;
      l2_address  <= '0;
      l2_wdata    <= '0;
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            gnt_d      <= pick_d;
            op_write   <= pick_wr;
            l2_read    <= ~pick_wr;
            l2_write   <= pick_wr;
            l2_address <= pick_addr;
            l2_wdata   <= pick_d ? d_wdata : '0;
            // Only a real conflict moves the round-robin pointer.
            if (i_req && d_req) last_grant <= pick_d;
            if (pick_d) begin
              if (d_grant_cnt != 16'hFFFF) d_grant_cnt <= d_grant_cnt + 16'd1;
            end else begin
              if (i_grant_cnt != 16'hFFFF) i_grant_cnt <= i_grant_cnt + 16'd1;
            end
            state <= L2_BUSY;
          end
        end
        L2_BUSY: begin
          if (l2_resp) begin
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            if (!op_write) line_buf <= l2_rdata;
            if (gnt_d) begin
              d_resp  <= 1'b1;
              d_rdata <= resp_line;
            end else begin
              i_resp  <= 1'b1;
              i_rdata <= resp_line;
            end
            state <= RESPOND;
          end
        end
        RESPOND: state <= RECOVER;
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Purpose: self-checking bench for l1_l2_arbiter with an L2 responder model and response scoreboard.
// Latency: L2 model answers a fixed number of cycles after seeing a request.
// Backpressure: L1 drivers hold requests until resp, then drop them.
module tb_l1_l2_arbiter;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         i_read = 1'b0;
  logic [15:0]  i_address = '0;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [15:0]  d_address = '0;
  logic [127:0] d_wdata = '0;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata = '0;
  logic         l2_resp;
  logic         l2_resp_m = 1'b0;
  logic         l2_resp_s = 1'b0;
  logic [15:0]  i_grant_cnt;
  logic [15:0]  d_grant_cnt;

  assign l2_resp = l2_resp_m | l2_resp_s;

  l1_l2_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_read      (i_read),
    .i_address   (i_address),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_address   (d_address),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .l2_read     (l2_read),
    .l2_write    (l2_write),
    .l2_address  (l2_address),
    .l2_wdata    (l2_wdata),
    .l2_rdata    (l2_rdata),
    .l2_resp     (l2_resp),
    .i_grant_cnt (i_grant_cnt),
    .d_grant_cnt (d_grant_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_i_cnt = 0;
  int exp_d_cnt = 0;
  int l2_delay  = 3;

  typedef struct { logic side_d; logic chk; logic [127:0] data; } resp_t;
  typedef struct { logic wr; logic [15:0] addr; logic [127:0] wdata; } l2_t;
  resp_t resp_q[$];
  l2_t   l2_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] l2_data(input logic [15:0] a);
    if (a == 16'h1230) return 128'hDEAD0123_4567_89AB_CDEF_0011_2233_BEEF;
    return {8{a ^ 16'h5A3C}};
  endfunction

  function automatic logic [127:0] sat(input int c);
    return (c > 65535) ? 128'(16'hFFFF) : 128'(c);
  endfunction

  // Record one expected transaction in both scoreboards, in service order.
  task automatic expect_txn(input logic side_d, input logic wr, input logic [15:0] addr,
                            input logic [127:0] wdata);
    logic [15:0] al;
    al = addr & 16'hFFF0;
    l2_q.push_back('{wr, al, wdata});
    resp_q.push_back('{side_d, !wr, l2_data(al)});
    if (side_d) exp_d_cnt++; else exp_i_cnt++;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_icnt"}, 128'(i_grant_cnt), sat(exp_i_cnt));
    check({tag, "_dcnt"}, 128'(d_grant_cnt), sat(exp_d_cnt));
  endtask

  task automatic check_drained(input string tag);
    repeat (4) @(negedge clk);
    check({tag, "_l2q_empty"}, 128'(l2_q.size()), 128'(0));
    check({tag, "_respq_empty"}, 128'(resp_q.size()), 128'(0));
  endtask

  task automatic run_i(input logic [15:0] addr);
    int t;
    @(posedge clk); #1;
    i_address = addr;
    i_read    = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!i_resp && t < 200);
    check("i_resp_seen", 128'(i_resp), 128'(1));
    @(posedge clk); #1;
    i_read    = 1'b0;
    i_address = 16'($urandom);
  endtask

  task automatic run_d(input logic [15:0] addr, input logic wr, input logic [127:0] wdata);
    int t;
    @(posedge clk); #1;
    d_address = addr;
    d_wdata   = wdata;
    d_read    = !wr;
    d_write   = wr;
    t = 0;
    do begin @(negedge clk); t++; end while (!d_resp && t < 200);
    check("d_resp_seen", 128'(d_resp), 128'(1));
    @(posedge clk); #1;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_address = 16'($urandom);
    d_wdata   = {4{$urandom}};
  endtask

  // L2 responder model: checks request fields stay stable, then pulses l2_resp.
  l2_t cur;
  bit  aborted;
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && (l2_read || l2_write)) begin
        if (l2_q.size() == 0) begin
          check("l2_unexpected", 128'({l2_read, l2_write}), 128'(0));
        end else begin
          cur = l2_q.pop_front();
          aborted = 1'b0;
          for (int k = 0; k < l2_delay; k++) begin
            if (!reset_n) begin aborted = 1'b1; break; end
            check("l2_address", 128'(l2_address), 128'(cur.addr));
            check("l2_write", 128'(l2_write), 128'(cur.wr));
            check("l2_read", 128'(l2_read), 128'(!cur.wr));
            if (cur.wr) check("l2_wdata", l2_wdata, cur.wdata);
            @(negedge clk);
          end
          if (!aborted && reset_n) begin
            @(posedge clk); #1;
            l2_resp_m = 1'b1;
            l2_rdata  = cur.wr ? ~l2_data(cur.addr) : l2_data(cur.addr);
            @(posedge clk); #1;
            l2_resp_m = 1'b0;
            l2_rdata  = {4{$urandom}};
            @(negedge clk);
            check("l1_resp_latency", 128'(i_resp | d_resp), 128'(1));
            check("l2_req_dropped", 128'({l2_read, l2_write}), 128'(0));
          end
        end
      end
    end
  end

  // Response scoreboard: every resp pulse must match the oldest expected transaction.
  resp_t er;
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && (i_resp || d_resp)) begin
        check("resp_exclusive", 128'(i_resp & d_resp), 128'(0));
        if (resp_q.size() == 0) begin
          check("resp_unexpected", 128'({i_resp, d_resp}), 128'(0));
        end else begin
          er = resp_q.pop_front();
          check("resp_side", 128'(d_resp), 128'(er.side_d));
          if (er.chk) check("resp_rdata", er.side_d ? d_rdata : i_rdata, er.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_l2_read", 128'(l2_read), 128'(0));
    check("rst_l2_write", 128'(l2_write), 128'(0));
    check("rst_l2_address", 128'(l2_address), 128'(0));
    check("rst_resps", 128'({i_resp, d_resp}), 128'(0));
    check("rst_i_rdata", i_rdata, 128'(0));
    check_cnts("rst");
    @(posedge clk); #1 reset_n = 1'b1;

    // Single I-read with request latency check.
    expect_txn(1'b0, 1'b0, 16'h123A, '0);
    fork
      run_i(16'h123A);
      begin
        @(posedge clk);
        @(negedge clk);
        check("l2_req_not_yet", 128'(l2_read), 128'(0));
        @(negedge clk);
        check("l2_req_latency", 128'(l2_read), 128'(1));
      end
    join
    check_drained("s1");
    check_cnts("s1");

    // D writeback.
    expect_txn(1'b1, 1'b1, 16'h4008, {16{8'hA5}});
    run_d(16'h4008, 1'b1, {16{8'hA5}});
    check_drained("s2");
    check_cnts("s2");

    // Spurious l2_resp in IDLE is ignored.
    @(posedge clk); #1 l2_resp_s = 1'b1;
    @(posedge clk); #1 l2_resp_s = 1'b0;
    check_drained("spur");
    check("spur_l2_idle", 128'({l2_read, l2_write}), 128'(0));
    check_cnts("spur");

    // Conflict after reset: I wins, then D.
    expect_txn(1'b0, 1'b0, 16'h2004, '0);
    expect_txn(1'b1, 1'b0, 16'h3018, '0);
    fork
      run_i(16'h2004);
      run_d(16'h3018, 1'b0, '0);
    join
    check_drained("s3");
    check_cnts("s3");

    // Repeated conflict: D wins this time.
    expect_txn(1'b1, 1'b0, 16'h5000, '0);
    expect_txn(1'b0, 1'b0, 16'h600F, '0);
    fork
      run_i(16'h600F);
      run_d(16'h5000, 1'b0, '0);
    join
    check_drained("s3b");
    check_cnts("s3b");

    // Back-to-back: D arrives while I is in flight, I held until its resp.
    expect_txn(1'b0, 1'b0, 16'h7001, '0);
    expect_txn(1'b1, 1'b1, 16'h8002, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    fork
      run_i(16'h7001);
      begin
        repeat (2) @(posedge clk);
        run_d(16'h8002, 1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      end
    join
    check_drained("s4");
    check_cnts("s4");

    // Reset mid-transaction.
    l2_delay = 20;
    l2_q.push_back('{1'b0, 16'h9000, '0});
    @(posedge clk); #1;
    i_address = 16'h9004;
    i_read    = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_l2_read", 128'(l2_read), 128'(1));
    #2 reset_n = 1'b0;
    #1;
    exp_i_cnt = 0;
    exp_d_cnt = 0;
    check("rst_async_l2_read", 128'(l2_read), 128'(0));
    check("rst_async_resps", 128'({i_resp, d_resp}), 128'(0));
    check_cnts("rst_async");
    i_read = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    l2_delay = 3;
    check("rst_l2q_consumed", 128'(l2_q.size()), 128'(0));
    expect_txn(1'b0, 1'b0, 16'hA5A7, '0);
    run_i(16'hA5A7);
    check_drained("post_rst");
    check_cnts("post_rst");

    // Saturation of the I grant counter from a preloaded 0xFFFE.
    @(negedge clk);
    force dut.i_grant_cnt = 16'hFFFE;
    @(posedge clk); #1;
    release dut.i_grant_cnt;
    exp_i_cnt = 65534;
    expect_txn(1'b0, 1'b0, 16'hB000, '0);
    run_i(16'hB000);
    check_drained("sat1");
    check_cnts("sat1");
    expect_txn(1'b0, 1'b0, 16'hB010, '0);
    run_i(16'hB010);
    check_drained("sat2");
    check_cnts("sat2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
